// File: rtl/imem_pkg.sv
// Shared constants and FSM state type for the instruction-memory loader.
// Consumed by imem_ram and imem_loader via import imem_pkg::*.
package imem_pkg;

    localparam int IMEM_DEPTH = 64;
    localparam int IMEM_AW    = 6;
    localparam int IMEM_LW    = 7;   // wide enough to hold a length of 64

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } loader_state_t;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// 64-entry instruction store: synchronous write, combinational read, no reset.
// Word width W follows the loader's instruction width.
module imem_ram
    import imem_pkg::*;
#(
    parameter int W = 32
) (
    input  logic               clk,
    input  logic               we,
    input  logic [IMEM_AW-1:0] waddr,
    input  logic [W-1:0]       wdata,
    input  logic [IMEM_AW-1:0] raddr,
    output logic [W-1:0]       rdata
);

    logic [W-1:0] mem [IMEM_DEPTH];

    // NOTE: the array has no reset; contents must survive a loader reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into a 64 x N instruction memory, little-endian per word.
// Optional session checksum on csum is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int N = 32   // legal widths: 16, 32, 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic [IMEM_AW-1:0] load_base,
    input  logic [IMEM_LW-1:0] load_len,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    input  logic [IMEM_AW-1:0] addr,
    output logic [N-1:0]       q,
    output logic               busy,
    output logic               done,
    output logic [IMEM_LW-1:0] wr_count,
    output logic [7:0]         csum
);

    localparam int BYTES = bytes_per_word(N);
    localparam int BCW   = 3;

    loader_state_t      state;
    logic [IMEM_AW-1:0] ptr;
    logic [IMEM_LW-1:0] len_q;
    logic [BCW-1:0]     byte_cnt;
    logic [N-1:0]       word_buf;
    logic               accept;
    logic               last_byte;
    logic               wr_en;

    assign accept    = in_valid && in_ready;
    assign last_byte = (byte_cnt == BCW'(BYTES - 1));
    assign wr_en     = (state == WRITE);

    // Outputs are registered alongside the state so they change only on edges.
    // NOTE: every register here uses <=; a blocking write would let later
    // branches observe the new value within the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            len_q    <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
            wr_count <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        ptr      <= load_base;
                        len_q    <= load_len;
                        wr_count <= '0;
                        byte_cnt <= '0;
                        if (load_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= COLLECT;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        for (int k = 0; k < BYTES; k++) begin
                            if (byte_cnt == BCW'(k)) begin
                                word_buf[8*k +: 8] <= in_data;
                            end
                        end
                        if (last_byte) begin
                            byte_cnt <= '0;
                            state    <= WRITE;
                            in_ready <= 1'b0;
                        end else begin
                            byte_cnt <= byte_cnt + BCW'(1);
                        end
                    end
                end
                WRITE: begin
                    // ptr is 6 bits wide, so 63 + 1 wraps to 0 naturally.
                    ptr      <= ptr + IMEM_AW'(1);
                    wr_count <= wr_count + IMEM_LW'(1);
                    if (wr_count + IMEM_LW'(1) == len_q) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state    <= COLLECT;
                        in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else if (state == IDLE && load_start) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= csum_q ^ in_data;
        end
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

    imem_ram #(
        .W(N)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en),
        .waddr(ptr),
        .wdata(word_buf),
        .raddr(addr),
        .rdata(q)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: one instance each of N=16/32/64 sharing clock and reset,
// checked against a queue-based stream model and a per-instance memory image.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic [5:0]  load_base;
    logic [6:0]  load_len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [5:0]  addr;
    int          sel;

    logic [2:0]  ls, iv, rdy, bsy, dn;
    logic [6:0]  wc [3];
    logic [7:0]  cs [3];
    logic [15:0] q16;
    logic [31:0] q32;
    logic [63:0] q64;

    logic        m_ready, m_busy, m_done;
    logic [6:0]  m_wc;
    logic [7:0]  m_cs;
    logic [63:0] m_q;

    int          checks = 0;
    int          errors = 0;

    logic [7:0]  stim_q [$];
    logic [63:0] mdl    [3][64];
    bit          known  [3][64];

    always #5 clk = ~clk;

    assign ls = {load_start && sel == 2, load_start && sel == 1, load_start && sel == 0};
    assign iv = {in_valid && sel == 2, in_valid && sel == 1, in_valid && sel == 0};

    imem_loader #(.N(16)) u_dut16 (
        .clk(clk), .reset(reset), .load_start(ls[0]), .load_base(load_base), .load_len(load_len),
        .in_valid(iv[0]), .in_data(in_data), .in_ready(rdy[0]), .addr(addr), .q(q16),
        .busy(bsy[0]), .done(dn[0]), .wr_count(wc[0]), .csum(cs[0]));

    imem_loader #(.N(32)) u_dut32 (
        .clk(clk), .reset(reset), .load_start(ls[1]), .load_base(load_base), .load_len(load_len),
        .in_valid(iv[1]), .in_data(in_data), .in_ready(rdy[1]), .addr(addr), .q(q32),
        .busy(bsy[1]), .done(dn[1]), .wr_count(wc[1]), .csum(cs[1]));

    imem_loader #(.N(64)) u_dut64 (
        .clk(clk), .reset(reset), .load_start(ls[2]), .load_base(load_base), .load_len(load_len),
        .in_valid(iv[2]), .in_data(in_data), .in_ready(rdy[2]), .addr(addr), .q(q64),
        .busy(bsy[2]), .done(dn[2]), .wr_count(wc[2]), .csum(cs[2]));

    always_comb begin
        case (sel)
            0: begin
                m_ready = rdy[0]; m_busy = bsy[0]; m_done = dn[0];
                m_wc = wc[0]; m_cs = cs[0]; m_q = {48'h0, q16};
            end
            1: begin
                m_ready = rdy[1]; m_busy = bsy[1]; m_done = dn[1];
                m_wc = wc[1]; m_cs = cs[1]; m_q = {32'h0, q32};
            end
            default: begin
                m_ready = rdy[2]; m_busy = bsy[2]; m_done = dn[2];
                m_wc = wc[2]; m_cs = cs[2]; m_q = q64;
            end
        endcase
    end

    function automatic int bytes_of(input int s);
        return (s == 0) ? 2 : (s == 1) ? 4 : 8;
    endfunction

    function automatic logic [7:0] exp_csum(input logic [7:0] x);
`ifdef IMEM_LOADER_CHECKSUM_EN
        return x;
`else
        return 8'h00;
`endif
    endfunction

    task automatic fill_random(input int n);
        stim_q.delete();
        repeat (n) stim_q.push_back(8'($urandom));
    endtask

    task automatic compare_mem(input int s, input string name);
        sel = s;
        for (int a = 0; a < 64; a++) begin
            addr = 6'(a);
            #1;
            if (known[s][a]) begin
                checks++;
                if (m_q !== mdl[s][a]) begin
                    errors++;
                    $display("FAIL %s mem[%0d] (inst %0d): got %h expected %h", name, a, s, m_q, mdl[s][a]);
                end
            end
        end
    endtask

    // Drives one session and checks handshake, read-around-write, done pulse and counts.
    task automatic run_session(input int s, input logic [5:0] base, input logic [6:0] len,
                               input int vmode, input int poke_cyc, input string name);
        int          bpw, acc, done_cnt, first_done, last_new, cyc, budget;
        bit          pend_write, pend_new;
        logic        v, r;
        logic [7:0]  b, xsum;
        logic [63:0] asm_word, new_word;
        logic [5:0]  wa;
        bpw = bytes_of(s);
        acc = 0; done_cnt = 0; first_done = -1; last_new = -1; cyc = 0;
        pend_write = 0; pend_new = 0; asm_word = '0; new_word = '0; xsum = '0;
        budget = int'(len) * (bpw + 1) * 4 + 20;
        sel = s;
        wa  = base;
        @(negedge clk);
        addr = wa; load_base = base; load_len = len; load_start = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        load_start = 1'b0;
        while (cyc < budget) begin
            if (pend_new) begin
                checks++;
                if (m_q !== new_word) begin
                    errors++;
                    $display("FAIL %s new word @%0d: got %h expected %h", name, wa, m_q, new_word);
                end
                mdl[s][wa] = new_word; known[s][wa] = 1'b1;
                wa = wa + 6'd1; addr = wa; pend_new = 0; last_new = cyc;
            end
            if (pend_write) begin
                checks++;
                if (m_ready !== 1'b0 || m_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s write cycle ready/busy: got %b/%b expected 0/1", name, m_ready, m_busy);
                end
                if (known[s][wa]) begin
                    checks++;
                    if (m_q !== mdl[s][wa]) begin
                        errors++;
                        $display("FAIL %s old word @%0d: got %h expected %h", name, wa, m_q, mdl[s][wa]);
                    end
                end
                pend_write = 0; pend_new = 1;
            end
            if (m_done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = cyc;
                if (done_cnt == 1) begin
                    checks++;
                    if (m_wc !== len || m_busy !== 1'b0 || m_ready !== 1'b0 || m_cs !== exp_csum(xsum)) begin
                        errors++;
                        $display("FAIL %s at done wc/busy/ready/csum: got %0d/%b/%b/%h expected %0d/0/0/%h",
                                 name, m_wc, m_busy, m_ready, m_cs, len, exp_csum(xsum));
                    end
                end
            end else if (done_cnt > 0) begin
                break;
            end
            if (cyc == poke_cyc) begin
                load_base = base ^ 6'h15; load_len = 7'd0; load_start = 1'b1;
            end else begin
                load_start = 1'b0;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (stim_q.size() == 0) v = 1'b0;
            in_valid = v;
            in_data  = v ? stim_q[0] : 8'($urandom);
            r = m_ready;
            @(posedge clk);
            if (v && r) begin
                b = stim_q.pop_front();
                xsum = xsum ^ b;
                asm_word[8*(acc % bpw) +: 8] = b;
                acc++;
                if (acc % bpw == 0) begin
                    pend_write = 1; new_word = asm_word; asm_word = '0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; load_start = 1'b0;
        checks++;
        if (cyc >= budget || done_cnt != 1) begin
            errors++;
            $display("FAIL %s done pulse count: got %0d expected 1 (cycles %0d)", name, done_cnt, cyc);
        end
        checks++;
        if (acc != int'(len) * bpw) begin
            errors++;
            $display("FAIL %s bytes accepted: got %0d expected %0d", name, acc, int'(len) * bpw);
        end
        checks++;
        if ((len == 0 && first_done != 0) || (len != 0 && first_done != last_new)) begin
            errors++;
            $display("FAIL %s done timing: got cycle %0d expected %0d", name, first_done, (len == 0) ? 0 : last_new);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if (m_ready !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_wc !== 7'd0 || m_cs !== 8'd0) begin
                errors++;
                $display("FAIL reset outputs inst %0d: got r%b b%b d%b wc%0d cs%h expected all zero",
                         s, m_ready, m_busy, m_done, m_wc, m_cs);
            end
        end
    endtask

    task automatic test_full_fill();
        for (int s = 0; s < 3; s++) begin
            fill_random(64 * bytes_of(s));
            run_session(s, 6'($urandom), 7'd64, 2, -1, "full_fill");
            compare_mem(s, "full_fill");
        end
    endtask

    task automatic test_basic();
        stim_q = '{8'h13, 8'h00, 8'h80, 8'hD2};
        run_session(1, 6'd0, 7'd1, 0, -1, "basic");
        sel = 1; addr = 6'd0; #1;
        checks++;
        if (m_q !== 64'hD280_0013) begin
            errors++;
            $display("FAIL basic q@0: got %h expected d2800013", m_q);
        end
        compare_mem(1, "basic");
    endtask

    task automatic test_wrap();
        logic [63:0] exp [3];
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp = '{64'h2211, 64'h4433, 64'h6655};
        run_session(0, 6'd62, 7'd3, 0, -1, "wrap");
        sel = 0;
        for (int i = 0; i < 3; i++) begin
            addr = 6'(62 + i); #1;
            checks++;
            if (m_q !== exp[i]) begin
                errors++;
                $display("FAIL wrap q@%0d: got %h expected %h", addr, m_q, exp[i]);
            end
        end
        compare_mem(0, "wrap");
    endtask

    task automatic test_valid_toggle();
        fill_random(16);
        run_session(2, 6'($urandom), 7'd2, 1, -1, "valid_toggle");
        compare_mem(2, "valid_toggle");
    endtask

    task automatic test_start_while_busy();
        fill_random(8);
        run_session(1, 6'($urandom), 7'd2, 0, 2, "start_busy");
        compare_mem(1, "start_busy");
        stim_q.delete();
        run_session(1, 6'($urandom), 7'd0, 0, -1, "len_zero");
        compare_mem(1, "len_zero");
    endtask

    task automatic test_mid_reset();
        logic [7:0] b [8];
        logic [5:0] base;
        logic       r;
        int         acc, cyc;
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        base = 6'($urandom);
        acc = 0; cyc = 0; sel = 1;
        @(negedge clk);
        addr = base; load_base = base; load_len = 7'd2; load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        while (acc < 5 && cyc < 50) begin
            in_valid = 1'b1; in_data = b[acc]; r = m_ready;
            @(posedge clk);
            if (r) acc++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (acc != 5 || m_wc !== 7'd1) begin
            errors++;
            $display("FAIL mid_reset pre-reset accepts/wc: got %0d/%0d expected 5/1", acc, m_wc);
        end
        mdl[1][base] = {32'h0, b[3], b[2], b[1], b[0]};
        known[1][base] = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (m_ready !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_wc !== 7'd0 || m_cs !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset async outputs: got r%b b%b d%b wc%0d cs%h expected all zero",
                     m_ready, m_busy, m_done, m_wc, m_cs);
        end
        @(negedge clk);
        reset = 1'b1;
        compare_mem(1, "mid_reset");
    endtask

    task automatic test_checksum();
        stim_q = '{8'h01, 8'h02, 8'h04, 8'h08};
        run_session(1, 6'($urandom), 7'd1, 0, -1, "checksum");
        sel = 1; #1;
        checks++;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (m_cs !== 8'h0F) begin
            errors++;
            $display("FAIL checksum csum: got %h expected 0f", m_cs);
        end
`else
        if (m_cs !== 8'h00) begin
            errors++;
            $display("FAIL checksum csum: got %h expected 00", m_cs);
        end
`endif
        compare_mem(1, "checksum");
    endtask

    task automatic test_back_to_back();
        int s;
        logic [6:0] len;
        for (int i = 0; i < 6; i++) begin
            s   = $urandom_range(0, 2);
            len = 7'($urandom_range(1, 5));
            fill_random(int'(len) * bytes_of(s));
            run_session(s, 6'($urandom), len, 2, -1, "back_to_back");
        end
        for (int s2 = 0; s2 < 3; s2++) compare_mem(s2, "back_to_back");
    endtask

    initial begin
        reset = 1'b0; load_start = 1'b0; load_base = '0; load_len = '0;
        in_valid = 1'b0; in_data = '0; addr = '0; sel = 0;
        for (int s = 0; s < 3; s++)
            for (int a = 0; a < 64; a++) begin
                known[s][a] = 1'b0; mdl[s][a] = '0;
            end
        #12;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        test_full_fill();
        test_basic();
        test_wrap();
        test_valid_toggle();
        test_start_while_busy();
        test_mid_reset();
        test_checksum();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter N, default 32, giving instruction word width in bits; only 16, 32 and 64 are legal.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port load_start, input, 1 bit: one-cycle request to begin a load session.
REQ-005 The block SHALL have port load_base, input, 6 bits: first word address of the session, sampled with load_start.
REQ-006 The block SHALL have port load_len, input, 7 bits: number of words to write (0..64), sampled with load_start.
REQ-007 The block SHALL have port in_valid, input, 1 bit: byte stream valid.
REQ-008 The block SHALL have port in_data, input, 8 bits: byte stream data.
REQ-009 The block SHALL have port in_ready, output, 1 bit: byte stream ready.
REQ-010 The block SHALL have port addr, input, 6 bits: fetch read address.
REQ-011 The block SHALL have port q, output, N bits: instruction word at addr.
REQ-012 The block SHALL have port busy, output, 1 bit: high while a session is collecting or writing.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse at session end.
REQ-014 The block SHALL have port wr_count, output, 7 bits: words written in the current or last session.
REQ-015 The block SHALL have port csum, output, 8 bits: session byte checksum (see Configuration).

Function
REQ-016 The block SHALL use FSM states IDLE, COLLECT, WRITE and DONE.
REQ-017 In IDLE, load_start=1 SHALL latch base and len, clear wr_count, byte counter and checksum, and go to COLLECT, or to DONE when load_len=0.
REQ-018 load_start SHALL be ignored in every state other than IDLE.
REQ-019 in_ready SHALL be 1 only in COLLECT; a byte SHALL be accepted on an edge where in_valid and in_ready are both 1.
REQ-020 Bytes SHALL assemble little-endian: byte k of a word goes to bits [8k+7:8k], with k = 0..N/8-1.
REQ-021 Accepting byte N/8-1 SHALL move COLLECT to WRITE; in_ready is 0 for that one cycle.
REQ-022 WRITE SHALL store the word at mem[ptr], increment ptr modulo 64 (address 63 wraps to 0), and increment wr_count.
REQ-023 After WRITE, the FSM SHALL go to DONE if wr_count equals len, else to COLLECT.
REQ-024 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-025 Latency from the last accepted byte edge SHALL be: memory updated on the next edge, done high in the following cycle.
REQ-026 busy SHALL be 1 in COLLECT and WRITE only.
REQ-027 Read SHALL be combinational: q = mem[addr] at all times, including during a session.
REQ-028 A read of the address being written SHALL return the old word until the WRITE edge and the new word after it.
REQ-029 load_len=64 SHALL overwrite the entire memory once, with the wrap handled as in REQ-022.

Reset
REQ-030 reset=0 SHALL immediately force state IDLE, in_ready 0, busy 0, done 0, wr_count 0, csum 0, and clear the byte counter and word buffer.
REQ-031 Memory contents SHALL NOT be affected by reset; words written before a mid-session reset are retained and a partial word is discarded.

Configuration
REQ-032 With IMEM_LOADER_CHECKSUM_EN defined, csum SHALL be the XOR of all bytes accepted since the last load_start, updated on each accept.
REQ-033 Without IMEM_LOADER_CHECKSUM_EN, csum SHALL be constant 0 and no checksum register SHALL exist.

Structure
REQ-034 Package imem_pkg SHALL hold IMEM_DEPTH=64, IMEM_AW=6 and the loader state enum typedef.
REQ-035 Storage SHALL be a sub-module imem_ram: 64 x N, synchronous write, asynchronous read, with no reset.

Verification
REQ-036 N=32, base=0, len=1, bytes 13,00,80,D2 → in_ready low 1 cycle, then q@0=D2800013, done pulse, wr_count=1.
REQ-037 N=16, base=62, len=3, bytes 11,22,33,44,55,66 → q@62=2211, q@63=4433, q@0=6655 (wrap).
REQ-038 N=64, len=2 with in_valid toggling every other cycle → only handshake-qualified bytes are stored; 16 bytes total are accepted.
REQ-039 load_start while busy, then load_len=0 → first is ignored; len=0 yields done one cycle after start, with no writes.
REQ-040 reset=0 after 5 bytes of a N=32, len=2 session → word 0 is retained, word 1 is unchanged, and all outputs are at their reset values asynchronously.
REQ-041 With IMEM_LOADER_CHECKSUM_EN defined, bytes 01,02,04,08 → csum=0F; without the macro, csum=00.
